// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one full-subtractor cell plus borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sd, sd_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, last;
  // full-subtractor cell on the current LSBs and the next-state decode
  always_comb begin
    d         = sa[0] ^ sb[0] ^ br;
    br_nxt    = (~sa[0] & (sb[0] ^ br)) | (sb[0] & br);
    sd_nxt    = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
    last      = cnt == CW'(WIDTH - 1);
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // operand shifters, borrow flop, bit counter and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      br  <= borrow_in;
      cnt <= '0;
      sd  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sd  <= sd_nxt;
      br  <= br_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff       <= sd_nxt;
        borrow_out <= br_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for the 8-bit and 1-bit serial subtractor
module tb_serial_subtractor;
  logic       clk = 0, rst = 1, start = 0, bin = 0;
  logic [7:0] a = 0, b = 0;
  logic       busy, done, bo;
  logic [7:0] diff;
  logic       start1 = 0, a1 = 0, b1 = 0, bin1 = 0;
  logic       busy1, done1, bo1, diff1;
  int         errs = 0, checks = 0, m_left = 0;
  logic [8:0] q[$];
  logic [8:0] held = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(bo));

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: an accepted request occupies WIDTH cycles of RUN plus one of DONE
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_left = 0;
      q.delete();
      held = 0;
    end else if (m_left == 0 && start) begin
      q.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
      m_left = 9;
    end else if (m_left > 0) m_left--;

  // monitor: compare status every cycle, pop the scoreboard when the model says done
  always @(negedge clk)
    if (!rst) begin
      chk("busy", busy, 32'(m_left > 0));
      chk("done", done, 32'(m_left == 1));
      if (m_left == 1) begin
        if (q.size() == 0) chk("scoreboard_empty", 1, 0);
        else held = q.pop_front();
      end
      chk("diff", diff, held[7:0]);
      chk("borrow_out", bo, held[8]);
    end

  task automatic wait_idle();
    int n = 0;
    while (m_left != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(m_left != 0), 0);
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; bin = c; start = 1;
    @(negedge clk);
    start = 0;
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", bo, 0);
    chk("rst_busy1", busy1, 0);
    #2 rst = 0;
    op(100, 37, 0);
    chk("t1_diff", diff, 8'h3F);
    chk("t1_bo", bo, 0);
    op(5, 9, 0);
    chk("t2a_diff", diff, 8'hFC);
    chk("t2a_bo", bo, 1);
    op(0, 0, 1);
    chk("t2b_diff", diff, 8'hFF);
    chk("t2b_bo", bo, 1);
    op(8'hFF, 8'hFF, 0);
    chk("t3a_diff", diff, 8'h00);
    chk("t3a_bo", bo, 0);
    op(8'h80, 8'h01, 1);
    chk("t3b_diff", diff, 8'h7E);
    chk("t3b_bo", bo, 0);
    @(negedge clk);
    a = 10; b = 3; bin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    end
    @(negedge clk);
    a = 1; b = 2; bin = 0; start = 1;
    wait_idle();
    chk("t4a_diff", diff, 8'd7);
    chk("t4a_bo", bo, 0);
    @(negedge clk);
    start = 0;
    chk("t4_accept", busy, 1);
    wait_idle();
    chk("t4b_diff", diff, 8'hFF);
    chk("t4b_bo", bo, 1);
    @(negedge clk);
    a = 200; b = 100; bin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_diff", diff, 0);
    chk("t5_bo", bo, 0);
    @(negedge clk);
    a = 50; b = 80; bin = 0; start = 1;
    #2 rst = 0;
    @(negedge clk);
    start = 0;
    chk("t5_accept", busy, 1);
    wait_idle();
    chk("t5_diff2", diff, 8'hE2);
    chk("t5_bo2", bo, 1);
    @(negedge clk);
    start = 1;
    repeat (300) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
    start = 0;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1;
      e = {1'b0, a1} - {1'b0, b1} - 2'(bin1);
      @(negedge clk);
      start1 = 0;
      chk("w1_busy_run", busy1, 1);
      chk("w1_done_early", done1, 0);
      @(negedge clk);
      chk("w1_done", done1, 1);
      chk("w1_diff", diff1, e[0]);
      chk("w1_bo", bo1, e[1]);
      @(negedge clk);
      chk("w1_done_clr", done1, 0);
      chk("w1_busy_clr", busy1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b - borrow_in, one bit per clock, LSB first.
- Contains one full-subtractor cell and a borrow flip-flop. Each cycle the cell's borrow_out is registered and fed back as the next cycle's borrow input.
- Used where area matters more than latency. It is a start/done wrapper around the single-bit subtractor cell and sits between the operand source and the result consumer.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on the accepting edge.
- b  input  WIDTH  subtrahend. Captured on the accepting edge.
- borrow_in  input  1  initial borrow. Captured on the accepting edge.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  registered difference. Holds until the next completion.
- borrow_out  output  1  registered final borrow. Holds until the next completion.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state = IDLE; busy, done, diff, borrow_out, shift registers, borrow flop and bit counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start = 1 at edge E0, load sa <= a, sb <= b, br <= borrow_in, cnt <= 0, sd <= 0, then go to RUN.
  - When start = 0, remain in IDLE.
- RUN, at each edge:
  - d = sa[0] ^ sb[0] ^ br.
  - br <= (~sa[0] & (sb[0] ^ br)) | (sb[0] & br).
  - sa and sb shift right by one. sd shifts right with d inserted at the MSB.
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1:
    - diff <= final sd value, including the current d.
    - borrow_out <= the new br.
    - done <= 1.
    - state <= DONE.
- DONE: for exactly one cycle, done = 1. On the next edge, done <= 0 and state <= IDLE.
- Latency and throughput:
  - The bit edges are E1..E_WIDTH.
  - done is high during the cycle following E_WIDTH, i.e. WIDTH edges after the accepting edge E0.
  - Next start is accepted no earlier than E_(WIDTH+2), giving a throughput of one op per WIDTH+2 cycles.
- busy = 1 in RUN and DONE, 0 in IDLE. It is a combinational decode of the state register.
- start while busy (RUN or DONE) is ignored. The in-flight operation and its operands are unaffected.
- Changes on a, b and borrow_in after E0 have no effect on the in-flight result.
- diff and borrow_out change only on the completing edge. Between operations they hold the last result.
- Arithmetic:
  - Result is (a - b - borrow_in) mod 2^WIDTH.
  - borrow_out = 1 iff a < b + borrow_in, unsigned, evaluated at WIDTH+1 bits.
- cnt width is $clog2(WIDTH+1) bits. For WIDTH = 1, RUN lasts exactly one edge.
- Reset asserted mid-RUN or mid-DONE:
  - All state returns immediately, asynchronously, to reset values.
  - No done pulse is produced for the aborted operation.
  - diff and borrow_out clear to 0.
- Reset released with start = 1: start is sampled on the first rising edge after deassertion, same as any IDLE cycle.

Test Plan:
1. WIDTH = 8: a = 100, b = 37, borrow_in = 0, start for 1 cycle -> busy for 9 cycles; done pulses exactly 8 edges after the accepting edge; diff = 63 (0x3F), borrow_out = 0.
2. WIDTH = 8: a = 5, b = 9, borrow_in = 0 -> diff = 0xFC, borrow_out = 1. Then a = 0, b = 0, borrow_in = 1 -> diff = 0xFF, borrow_out = 1.
3. WIDTH = 8: a = 0xFF, b = 0xFF, borrow_in = 0 -> diff = 0x00, borrow_out = 0. Then a = 0x80, b = 0x01, borrow_in = 1 -> diff = 0x7E, borrow_out = 0.
4. Busy handling:
   - Assert start with a = 10, b = 3; re-assert start with a = 1, b = 2 during RUN and during DONE; also toggle the a/b inputs -> single done with diff = 7, borrow_out = 0.
   - The second request is accepted only if start is held into IDLE, producing diff = 0xFF, borrow_out = 1.
5. Reset mid-operation: start a = 200, b = 100; assert rst asynchronously (between edges) at bit 4 -> busy, done, diff and borrow_out go to 0 immediately; no done pulse follows. A fresh op after release is correct.
6. Randomized back-to-back sweep, plus a WIDTH = 1 instance exhaustively (8 input combos):
   - Compare each result against {borrow_out, diff} == ({1'b0, a} - b - borrow_in) taken at WIDTH+1 bits.
   - WIDTH = 1: done one edge after the accepting edge.
